// File: rtl/alu_issue_wb.sv
// Issue/writeback wrapper for a combinational ALU: R-type decode, 32x32 register file,
// ID/EX and EX/WB registers, WB->ID bypass and EX-dependency stall.
module alu_issue_wb #(
    parameter bit          FWD_EN      = 1'b1,
    parameter logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [31:0] alu_rs,
    output logic [31:0] alu_rt,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_rd,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal,
    output logic        div0,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_data
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned OPW  = 4;
    localparam int unsigned NREG = 32;

    localparam logic [OPW-1:0] OP_ADD = 4'b1000;
    localparam logic [OPW-1:0] OP_SUB = 4'b0100;
    localparam logic [OPW-1:0] OP_MUL = 4'b0010;
    localparam logic [OPW-1:0] OP_DIV = 4'b0001;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_rs_q, ex_rs_d;
    logic [XLEN-1:0] ex_rt_q, ex_rt_d;
    logic [OPW-1:0]  ex_op_q, ex_op_d;
    logic [RW-1:0]   ex_dst_q, ex_dst_d;

    logic            wb_valid_q, wb_valid_d;
    logic [RW-1:0]   wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            div0_q, div0_d;
    logic            illegal_q, illegal_d;

    logic [RW-1:0]   dec_rs, dec_rt, dec_rd;
    logic [OPW-1:0]  dec_op;
    logic            dec_legal;
    logic            ex_hit, wb_hit, accept;
    logic [XLEN-1:0] src_rs_val, src_rt_val;

    // shamt is not part of the decode
    logic unused_shamt;
    assign unused_shamt = ^in_instr[10:6];

    // Instruction decode
    always_comb begin
        dec_rs    = in_instr[25:21];
        dec_rt    = in_instr[20:16];
        dec_rd    = in_instr[15:11];
        dec_op    = '0;
        dec_legal = 1'b0;
        if (in_instr[31:26] == 6'd0) begin
            dec_legal = 1'b1;
            case (in_instr[5:0])
                6'h20:   dec_op = OP_ADD;
                6'h22:   dec_op = OP_SUB;
                6'h18:   dec_op = OP_MUL;
                6'h1A:   dec_op = OP_DIV;
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // Hazard detection; WB entries only stall when the bypass is disabled
    always_comb begin
        ex_hit   = ex_valid_q && (ex_dst_q != '0) &&
                   ((ex_dst_q == dec_rs) || (ex_dst_q == dec_rt));
        wb_hit   = !FWD_EN && wb_valid_q && (wb_addr_q != '0) &&
                   ((wb_addr_q == dec_rs) || (wb_addr_q == dec_rt));
        in_ready = !(in_valid && dec_legal && (ex_hit || wb_hit));
        accept   = in_valid && in_ready;
    end

    // Operand read with WB bypass
    always_comb begin
        src_rs_val = regs_q[dec_rs];
        src_rt_val = regs_q[dec_rt];
        if (FWD_EN && wb_valid_q && (wb_addr_q == dec_rs) && (dec_rs != '0)) begin
            src_rs_val = wb_data_q;
        end
        if (FWD_EN && wb_valid_q && (wb_addr_q == dec_rt) && (dec_rt != '0)) begin
            src_rt_val = wb_data_q;
        end
    end

    // ID/EX load; empty EX presents zeros to the ALU
    always_comb begin
        ex_valid_d = accept && dec_legal;
        ex_rs_d    = '0;
        ex_rt_d    = '0;
        ex_op_d    = '0;
        ex_dst_d   = '0;
        if (ex_valid_d) begin
            ex_rs_d  = src_rs_val;
            ex_rt_d  = src_rt_val;
            ex_op_d  = dec_op;
            ex_dst_d = dec_rd;
        end
        illegal_d = accept && !dec_legal;
    end

    // EX/WB capture with divide-by-zero substitution
    always_comb begin
        wb_valid_d = ex_valid_q;
        wb_addr_d  = '0;
        wb_data_d  = '0;
        div0_d     = ex_valid_q && (ex_op_q == OP_DIV) && (ex_rt_q == '0);
        if (ex_valid_q) begin
            wb_addr_d = ex_dst_q;
            wb_data_d = div0_d ? DIV0_RESULT : alu_rd;
        end
    end

    // Register array update: WB write overrides a same-address debug write
    always_comb begin
        regs_d = regs_q;
        if (dbg_we) begin
            regs_d[dbg_addr] = dbg_wdata;
        end
        if (wb_valid_q) begin
            regs_d[wb_addr_q] = wb_data_q;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_op_q    <= '0;
            ex_dst_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            div0_q     <= 1'b0;
            illegal_q  <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_op_q    <= ex_op_d;
            ex_dst_q   <= ex_dst_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            div0_q     <= div0_d;
            illegal_q  <= illegal_d;
            regs_q     <= regs_d;
        end
    end

    assign alu_rs   = ex_rs_q;
    assign alu_rt   = ex_rt_q;
    assign alu_op   = ex_op_q;
    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign illegal  = illegal_q;
    assign div0     = div0_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: doc/alu_issue_wb.md
# alu_issue_wb

Issue/writeback wrapper around the combinational ALU. Decodes MIPS R-type instruction words and reads operands from a 32x32 register file. Drives the ALU's rs/rt/op inputs from an ID/EX register, captures rd into an EX/WB register, and writes the result back. Resolves data hazards by bypassing from writeback and stalling on an EX-stage dependency.

## Interface
- FWD_EN, 1: 1 enables the WB->ID bypass; 0 stalls on WB hazards as well.
- DIV0_RESULT, 32'hFFFFFFFF: result written when a div has rt operand == 0.
- Clock is `clk`; reset is `rst_n`, asynchronous, active-low.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  in_instr valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  32  R-type word: rs[25:21], rt[20:16], rd[15:11], funct[5:0].
- alu_rs, alu_rt  out  32 each  operands to ALU.
- alu_op  out  4  one-hot ALU op.
- alu_rd  in  32  ALU result, combinational from alu_rs/alu_rt/alu_op.
- wb_valid  out  1  writeback this cycle.
- wb_addr  out  5  writeback register.
- wb_data  out  32  writeback value.
- illegal  out  1  one-cycle pulse, rejected instruction.
- div0  out  1  one-cycle pulse, coincident with wb_valid of a div-by-zero.
- dbg_we  in  1  debug register write.
- dbg_addr  in  5  debug read/write address.
- dbg_wdata  in  32  debug write data.
- dbg_data  out  32  combinational read of register dbg_addr (array contents, no bypass).

## Operation
- Accept when in_valid && in_ready.
- Decode:
  - opcode[31:26] must be 0.
  - funct 0x20 add->4'b1000, 0x22 sub->4'b0100, 0x18 mul->4'b0010, 0x1A div->4'b0001.
  - Anything else is illegal: accepted, dropped, no EX entry, illegal pulses the next cycle.
- Register file:
  - r0 reads 0 always; writes to r0 are discarded.
  - A write with rd=0 still produces wb_valid=1 and wb_addr=0.
- Operand read order:
  - WB bypass (FWD_EN=1, wb_valid, wb_addr==src, src!=0).
  - Otherwise register array.
- Hazard (in_ready=0) when in_valid and an EX entry is valid with dst!=0 equal to the decoded rs or rt field.
  - With FWD_EN=0, the same rule also applies to the WB entry.
  - Illegal words never cause a stall.
- EX->WB capture:
  - wb_data = DIV0_RESULT if op is div and alu_rt==0; otherwise alu_rd.
  - div0 is set accordingly.
- Write priority: the WB write to the array is at the end of the WB cycle. dbg_we in the same cycle to the same address is ignored; WB wins.
- Arithmetic is 32-bit unsigned, truncated; mul keeps the low 32 bits.

## Timing
- Reset: register array all 0, EX and WB valid cleared. alu_rs/alu_rt/alu_op=0, wb_valid/wb_addr/wb_data=0, illegal=0, div0=0, in_ready=1. Asynchronous assertion mid-operation discards all in-flight instructions.
- Accept at edge N:
  - Cycle N+1: alu_* show the instruction; alu_* = 0 when EX is empty.
  - Cycle N+2: wb_valid=1 with wb_addr/wb_data.
  - Register array updated at the end of N+2.
- Throughput is one instruction per cycle absent hazards.
- Dependent instruction immediately after its producer: 1 stall cycle with FWD_EN=1, 2 stall cycles with FWD_EN=0.
- in_ready is combinational from in_instr and EX/WB state. No combinational path from in_valid to in_ready except the hazard gating.

## Test plan
- Reset: assert rst_n=0 mid-stream -> wb_valid=0 next sample, dbg_data=0 for all 32 addresses, in_ready=1.
- Add: preload r1=12, r2=13 via dbg, issue add r3,r1,r2 (0x00221820) at N -> N+1: alu_op=1000, alu_rs=12, alu_rt=13; N+2: wb_valid=1, wb_addr=3, wb_data=25; dbg r3=25.
- EX hazard: sub r4,r3,r1 offered the cycle after the add -> in_ready=0 for one cycle, then alu_rs=25, alu_rt=12, wb_data=13.
- WB bypass: add, one unrelated instruction, then mul r5,r3,r3 -> no stall, alu_rs=alu_rt=25, wb_data=625. Repeat with FWD_EN=0 -> one stall, same result.
- Divide: preload r2=5. div r6,r3,r2 -> 5. div r6,r1,r0 -> wb_data=FFFFFFFF, div0=1 for one cycle.
- Illegal/r0: funct 0x21 -> illegal pulse, no wb_valid. add r0,r1,r2 -> wb_valid=1 but dbg r0=0. Simultaneous dbg_we to r3 during a WB to r3 -> WB value retained.
